// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Parametrised Fibonacci/Galois LFSR with period tracking; optional LFSR_LOCKUP_RECOVER_EN
module lfsr_gen #(
    parameter int                 WIDTH = 5,
    parameter logic [WIDTH-1:0]   TAPS  = 5'b00101,
    parameter bit                 MODE  = 1'b0,
    parameter logic [WIDTH-1:0]   SEED  = 5'b11111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             lockup
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic             fb;

    // One LFSR step from the current state in the configured topology
    always_comb begin
        fb        = ^(state_q & TAPS);
        fib_next  = {fb, state_q[WIDTH-1:1]};
        gal_next  = (state_q >> 1) ^ ({WIDTH{state_q[0]}} & TAPS);
        step_next = MODE ? gal_next : fib_next;
`ifdef LFSR_LOCKUP_RECOVER_EN
        // All-zero is a fixed point; only an upset can get here, so kick back to SEED
        if (state_q == '0) begin
            step_next = SEED;
        end
`endif
    end

    // Next-state selection: load beats en beats hold; wrap is a single-cycle pulse
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        lockup_d = lockup_q;
        if (load) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            state_d = (seed_in == '0) ? SEED : seed_in;
`else
            state_d = seed_in;
`endif
            ref_d   = state_d;
            cnt_d   = '0;
        end else if (en) begin
            state_d = step_next;
            if (step_next == ref_q) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + WIDTH'(1);
            end
        end
        if (load || en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup_d = 1'b0;
`else
            lockup_d = (state_d == '0);
`endif
        end
    end

    // State registers with asynchronous active-low reset to the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEED;
            ref_q    <= SEED;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign state   = state_q;
    assign bit_out = state_q[0];
    assign cnt     = cnt_q;
    assign wrap    = wrap_q;
    assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - Self-checking bench for lfsr_gen (Fibonacci default and maximal Galois instance)
module tb_lfsr_gen;

    localparam logic [4:0] SEED   = 5'b11111;
    localparam logic [4:0] TAPS_A = 5'b00101;
    localparam logic [4:0] TAPS_B = 5'b10100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [4:0] seed_in = 5'b0;

    logic [4:0] st_a, cnt_a, st_b, cnt_b;
    logic       bo_a, wr_a, lk_a, bo_b, wr_b, lk_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(5), .TAPS(TAPS_A), .MODE(1'b0), .SEED(SEED)) u_fib (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .state(st_a), .bit_out(bo_a), .cnt(cnt_a), .wrap(wr_a), .lockup(lk_a)
    );

    lfsr_gen #(.WIDTH(5), .TAPS(TAPS_B), .MODE(1'b1), .SEED(SEED)) u_gal (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .state(st_b), .bit_out(bo_b), .cnt(cnt_b), .wrap(wr_b), .lockup(lk_b)
    );

    // Reference model: index 0 = Fibonacci instance, 1 = Galois instance
    logic [4:0] m_state [2];
    logic [4:0] m_ref   [2];
    logic [4:0] m_cnt   [2];
    logic       m_wrap  [2];
    logic       m_lock  [2];

    function automatic logic [4:0] m_next(input logic [4:0] s, input bit gal, input logic [4:0] t);
        int fb;
        if (gal)
            return s[0] ? ((s >> 1) ^ t) : (s >> 1);
        fb = $countones(s & t) % 2;
        return 5'((fb * 16) + int'(s) / 2);
    endfunction

    function automatic bit recover_on();
`ifdef LFSR_LOCKUP_RECOVER_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] nx;
            if (!rst_n) begin
                m_state[i] = SEED; m_ref[i] = SEED; m_cnt[i] = 0; m_wrap[i] = 0; m_lock[i] = 0;
            end else if (load) begin
                m_state[i] = (recover_on() && seed_in == 0) ? SEED : seed_in;
                m_ref[i]   = m_state[i];
                m_cnt[i]   = 0;
                m_wrap[i]  = 0;
                m_lock[i]  = !recover_on() && (m_state[i] == 0);
            end else if (en) begin
                nx = m_next(m_state[i], i == 1, (i == 1) ? TAPS_B : TAPS_A);
                if (recover_on() && m_state[i] == 0) nx = SEED;
                m_state[i] = nx;
                if (nx == m_ref[i]) begin m_cnt[i] = 0; m_wrap[i] = 1; end
                else begin m_cnt[i] = m_cnt[i] + 1; m_wrap[i] = 0; end
                m_lock[i] = !recover_on() && (nx == 0);
            end else begin
                m_wrap[i] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("fib_state", 32'(st_a), 32'(m_state[0]));
            check("fib_bit",   32'(bo_a), 32'(m_state[0][0]));
            check("fib_cnt",   32'(cnt_a), 32'(m_cnt[0]));
            check("fib_wrap",  32'(wr_a), 32'(m_wrap[0]));
            check("fib_lock",  32'(lk_a), 32'(m_lock[0]));
            check("gal_state", 32'(st_b), 32'(m_state[1]));
            check("gal_bit",   32'(bo_b), 32'(m_state[1][0]));
            check("gal_cnt",   32'(cnt_b), 32'(m_cnt[1]));
            check("gal_wrap",  32'(wr_b), 32'(m_wrap[1]));
            check("gal_lock",  32'(lk_b), 32'(m_lock[1]));
        end
    end

    task automatic cyc(input bit e, input bit l, input logic [4:0] s);
        en = e; load = l; seed_in = s;
        @(posedge clk); #1;
        en = 0; load = 0;
    endtask

    bit seen [32];
    int distinct;
    bit zero_seen;

    initial begin
        @(posedge clk); #1;
        chk_on = 1'b1;
        check("rst_state", 32'(st_a), 32'h1f);
        check("rst_cnt",   32'(cnt_a), 0);
        check("rst_wrap",  32'(wr_a), 0);
        check("rst_lock",  32'(lk_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Steps 1-4 of the Fibonacci sequence, plus first Galois state
        cyc(1, 0, 0);
        check("fib_s1", 32'(st_a), 32'b01111);
        check("gal_s1", 32'(st_b), 32'b11011);
        cyc(1, 0, 0);
        check("fib_s2", 32'(st_a), 32'b00111);
        cyc(1, 0, 0);
        check("fib_s3", 32'(st_a), 32'b00011);
        check("bit_s3", 32'(bo_a), 1);
        cyc(1, 0, 0);
        check("fib_s4", 32'(st_a), 32'b10001);

        // Period from reset: 31 steps, Galois states all distinct and non-zero
        rst_n = 0; #2; rst_n = 1;
        for (int i = 0; i < 32; i++) seen[i] = 0;
        distinct = 0; zero_seen = 0;
        for (int k = 1; k <= 31; k++) begin
            cyc(1, 0, 0);
            if (st_b == 0) zero_seen = 1;
            if (!seen[st_b]) distinct++;
            seen[st_b] = 1;
            if (k == 30) begin
                check("cnt30", 32'(cnt_a), 30);
                check("nowrap30", 32'(wr_a), 0);
            end
        end
        check("wrap31_state", 32'(st_a), 32'h1f);
        check("wrap31_pulse", 32'(wr_a), 1);
        check("wrap31_cnt",   32'(cnt_a), 0);
        check("gal_distinct", 32'(distinct), 31);
        check("gal_nonzero",  32'(zero_seen), 0);
        check("gal_wrap31",   32'(wr_b), 1);
        check("gal_state31",  32'(st_b), 32'h1f);
        cyc(0, 0, 0);
        check("wrap_one_cycle", 32'(wr_a), 0);
        check("hold_state", 32'(st_a), 32'h1f);

        // Load takes priority over en
        cyc(1, 1, 5'b00001);
        check("load_state", 32'(st_a), 32'b00001);
        check("load_cnt",   32'(cnt_a), 0);
        for (int k = 1; k <= 31; k++) cyc(1, 0, 0);
        check("load_wrap", 32'(wr_a), 1);
        check("load_wrap_state", 32'(st_a), 32'b00001);

        // Zero seed
        cyc(0, 1, 5'b00000);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("zero_load_state", 32'(st_a), 32'h1f);
        check("zero_load_lock",  32'(lk_a), 0);
`else
        check("zero_load_state", 32'(st_a), 0);
        check("zero_load_lock",  32'(lk_a), 1);
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        check("zero_hold_state", 32'(st_a), 0);
        check("zero_hold_lock",  32'(lk_a), 1);
        check("zero_ref_wrap",   32'(wr_a), 1);
        cyc(0, 1, 5'b00001);
        check("lock_cleared", 32'(lk_a), 0);
`endif

        // Asynchronous reset between edges
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async_state", 32'(st_a), 32'h1f);
        check("async_cnt",   32'(cnt_a), 0);
        check("async_wrap",  32'(wr_a), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1, 0, 0);
        check("restart_s1", 32'(st_a), 32'b01111);
        cyc(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
